// File: rtl/rgb_cmd_pwm.sv
// rgb_cmd_pwm: decodes UART colour commands into per-LED duties and drives active-low RGB PWM.
// Build option: `RGB_GAMMA_EN applies a square-law gamma to every committed duty.
module rgb_cmd_pwm #(
   parameter int unsigned PWM_BITS       = 8,
   parameter int unsigned TIMEOUT_CYCLES = 120000
) (
   input  logic       int_clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_data_ready,
   output logic       rgb1_red,
   output logic       rgb1_green,
   output logic       rgb1_blue,
   output logic       rgb2_red,
   output logic       rgb2_green,
   output logic       rgb2_blue,
   output logic       cmd_done,
   output logic       cmd_error
);

   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'((2 ** PWM_BITS) - 2);
   localparam logic [TO_W-1:0]     TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HEX  = 1'b1;

   logic [0:0]                     state_q, state_d;
   logic [23:0]                    stg_q, stg_d;
   logic [2:0]                     dcnt_q, dcnt_d;
   logic [TO_W-1:0]                to_q, to_d;
   logic [1:0]                     tgt_q, tgt_d;
   logic [1:0][2:0][PWM_BITS-1:0]  pend_q, pend_d;
   logic [1:0][2:0][PWM_BITS-1:0]  act_q, act_d;
   logic [PWM_BITS-1:0]            cnt_q, cnt_d;
   logic [1:0][2:0]                led_q, led_d;
   logic                           done_q, done_d;
   logic                           err_q, err_d;
   logic                           commit;
   logic [2:0][7:0]                com_val;
   logic [4:0]                     nib;

   // {valid, nibble} for an ASCII hex digit
   function automatic logic [4:0] hex_nib(input logic [7:0] b);
      if (b >= "0" && b <= "9") return {1'b1, 4'(b - 8'h30)};
      if (b >= "a" && b <= "f") return {1'b1, 4'(b - 8'h57)};
      if (b >= "A" && b <= "F") return {1'b1, 4'(b - 8'h37)};
      return 5'd0;
   endfunction

   function automatic logic [7:0] gamma(input logic [7:0] d);
`ifdef RGB_GAMMA_EN
      return 8'((16'(d) * 16'(d) + 16'd255) >> 8);
`else
      return d;
`endif
   endfunction

   // Command decoder: next state, staging, target and pending duties
   always_comb begin
      state_d = state_q;
      stg_d   = stg_q;
      dcnt_d  = dcnt_q;
      to_d    = to_q;
      tgt_d   = tgt_q;
      pend_d  = pend_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      commit  = 1'b0;
      com_val = '0;
      nib     = hex_nib(rx_data);

      case (state_q)
         ST_IDLE: begin
            if (rx_data_ready) begin
               case (rx_data)
                  "1": tgt_d = 2'b01;
                  "2": tgt_d = 2'b10;
                  "a": tgt_d = 2'b11;
                  "r": begin commit = 1'b1; com_val = {8'h00, 8'h00, 8'hFF}; end
                  "g": begin commit = 1'b1; com_val = {8'h00, 8'hFF, 8'h00}; end
                  "b": begin commit = 1'b1; com_val = {8'hFF, 8'h00, 8'h00}; end
                  "w": begin commit = 1'b1; com_val = '1; end
                  "k": begin commit = 1'b1; com_val = '0; end
                  "#": begin
                     state_d = ST_HEX;
                     stg_d   = '0;
                     dcnt_d  = '0;
                     to_d    = '0;
                  end
                  default: ;
               endcase
            end
         end
         ST_HEX: begin
            if (rx_data_ready) begin
               to_d = '0;
               if (nib[4]) begin
                  stg_d = {stg_q[19:0], nib[3:0]};
                  if (dcnt_q == 3'd5) begin
                     commit  = 1'b1;
                     com_val = {stg_d[7:0], stg_d[15:8], stg_d[23:16]};
                     state_d = ST_IDLE;
                     dcnt_d  = '0;
                  end else begin
                     dcnt_d = dcnt_q + 3'd1;
                  end
               end else if (rx_data == "#") begin
                  stg_d  = '0;
                  dcnt_d = '0;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (to_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (commit) begin
         done_d = 1'b1;
         for (int l = 0; l < 2; l++) begin
            if (tgt_q[l]) begin
               for (int c = 0; c < 3; c++) pend_d[l][c] = PWM_BITS'(gamma(com_val[c]));
            end
         end
      end
   end

   // PWM: active duties reload only at wrap; pins registered from next-cycle values
   always_comb begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + PWM_BITS'(1);
      act_d = (cnt_q == CNT_MAX) ? pend_q : act_q;
      led_d = '1;
      for (int l = 0; l < 2; l++) begin
         for (int c = 0; c < 3; c++) led_d[l][c] = ~(cnt_d < act_d[l][c]);
      end
   end

   always_ff @(posedge int_clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         stg_q   <= '0;
         dcnt_q  <= '0;
         to_q    <= '0;
         tgt_q   <= 2'b11;
         pend_q  <= '0;
         act_q   <= '0;
         cnt_q   <= '0;
         led_q   <= '1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stg_q   <= stg_d;
         dcnt_q  <= dcnt_d;
         to_q    <= to_d;
         tgt_q   <= tgt_d;
         pend_q  <= pend_d;
         act_q   <= act_d;
         cnt_q   <= cnt_d;
         led_q   <= led_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign rgb1_red   = led_q[0][0];
   assign rgb1_green = led_q[0][1];
   assign rgb1_blue  = led_q[0][2];
   assign rgb2_red   = led_q[1][0];
   assign rgb2_green = led_q[1][1];
   assign rgb2_blue  = led_q[1][2];
   assign cmd_done   = done_q;
   assign cmd_error  = err_q;

endmodule

// File: tb/tb_rgb_cmd_pwm.sv
// Bench for rgb_cmd_pwm: command-level reference model compared every cycle, plus
// hand-computed pin duty counts and pulse timing.
module tb_rgb_cmd_pwm;

   localparam int TO     = 1000;
   localparam int PERIOD = 255;

   logic       int_clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_data_ready = 1'b0;
   logic       rgb1_red, rgb1_green, rgb1_blue, rgb2_red, rgb2_green, rgb2_blue;
   logic       cmd_done, cmd_error;
   logic [5:0] pins;

   int checks = 0;
   int errors = 0;
   int n_done = 0;
   int n_err  = 0;
   int low [6];

   rgb_cmd_pwm #(.PWM_BITS(8), .TIMEOUT_CYCLES(TO)) dut (
      .int_clk(int_clk), .rst(rst), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
      .rgb1_red(rgb1_red), .rgb1_green(rgb1_green), .rgb1_blue(rgb1_blue),
      .rgb2_red(rgb2_red), .rgb2_green(rgb2_green), .rgb2_blue(rgb2_blue),
      .cmd_done(cmd_done), .cmd_error(cmd_error)
   );

   always #5 int_clk = ~int_clk;

   assign pins = {rgb2_blue, rgb2_green, rgb2_red, rgb1_blue, rgb1_green, rgb1_red};

   // Reference model: period index, pending/active duty tables and command parser state
   int         m_cnt;
   logic [7:0] m_pend [2][3];
   logic [7:0] m_act  [2][3];
   logic [1:0] m_tgt;
   bit         m_hex;
   int         m_dig, m_val, m_silent;
   bit         m_done, m_err;

   function automatic int hexval(input logic [7:0] b);
      if (b >= "0" && b <= "9") return int'(b) - 48;
      if (b >= "a" && b <= "f") return int'(b) - 87;
      if (b >= "A" && b <= "F") return int'(b) - 55;
      return -1;
   endfunction

   function automatic logic [7:0] gam(input int d);
`ifdef RGB_GAMMA_EN
      return 8'((d * d + 255) / 256);
`else
      return 8'(d);
`endif
   endfunction

   task automatic m_commit(input int r, input int g, input int b);
      for (int l = 0; l < 2; l++) begin
         if (m_tgt[l]) begin
            m_pend[l][0] = gam(r);
            m_pend[l][1] = gam(g);
            m_pend[l][2] = gam(b);
         end
      end
      m_done = 1'b1;
   endtask

   task automatic m_byte(input logic [7:0] b);
      int hv;
      if (!m_hex) begin
         case (b)
            "1": m_tgt = 2'b01;
            "2": m_tgt = 2'b10;
            "a": m_tgt = 2'b11;
            "r": m_commit(255, 0, 0);
            "g": m_commit(0, 255, 0);
            "b": m_commit(0, 0, 255);
            "w": m_commit(255, 255, 255);
            "k": m_commit(0, 0, 0);
            "#": begin m_hex = 1'b1; m_dig = 0; m_val = 0; m_silent = 0; end
            default: ;
         endcase
      end else begin
         m_silent = 0;
         hv = hexval(b);
         if (hv >= 0) begin
            m_val = m_val * 16 + hv;
            m_dig++;
            if (m_dig == 6) begin
               m_commit((m_val >> 16) & 255, (m_val >> 8) & 255, m_val & 255);
               m_hex = 1'b0;
            end
         end else if (b == "#") begin
            m_dig = 0;
            m_val = 0;
         end else begin
            m_err = 1'b1;
            m_hex = 1'b0;
         end
      end
   endtask

   always @(posedge int_clk or posedge rst) begin
      if (rst) begin
         m_cnt = 0; m_tgt = 2'b11; m_hex = 1'b0; m_dig = 0; m_val = 0; m_silent = 0;
         m_done = 1'b0; m_err = 1'b0;
         for (int l = 0; l < 2; l++)
            for (int c = 0; c < 3; c++) begin m_pend[l][c] = 8'h00; m_act[l][c] = 8'h00; end
      end else begin
         m_done = 1'b0;
         m_err  = 1'b0;
         if (m_cnt == PERIOD - 1) begin
            m_cnt = 0;
            m_act = m_pend;
         end else begin
            m_cnt++;
         end
         if (rx_data_ready) m_byte(rx_data);
         else if (m_hex) begin
            m_silent++;
            if (m_silent == TO) begin m_err = 1'b1; m_hex = 1'b0; end
         end
      end
   end

   // Per-cycle compare of all outputs against the model
   always @(negedge int_clk) begin
      logic [7:0] expv, actv;
      for (int i = 0; i < 6; i++) expv[i+2] = (m_cnt < int'(m_act[i/3][i%3])) ? 1'b0 : 1'b1;
      expv[1] = m_done;
      expv[0] = m_err;
      actv = {pins, cmd_done, cmd_error};
      checks++;
      if (actv !== expv) begin
         errors++;
         $display("FAIL cycle_cmp t=%0t got=%b exp=%b", $time, actv, expv);
      end
      if (cmd_done) n_done++;
      if (cmd_error) n_err++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) begin
         rx_data = s[i];
         rx_data_ready = 1'b1;
         @(negedge int_clk);
      end
      rx_data_ready = 1'b0;
   endtask

   task automatic settle();
      repeat (PERIOD + 1) @(negedge int_clk);
   endtask

   task automatic measure();
      for (int i = 0; i < 6; i++) low[i] = 0;
      repeat (PERIOD) begin
         @(negedge int_clk);
         for (int i = 0; i < 6; i++) if (!pins[i]) low[i]++;
      end
   endtask

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog expired t=%0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      int sd, se, c;
`ifdef RGB_GAMMA_EN
      localparam int D80 = 64, D12 = 2, D34 = 11, D56 = 29;
`else
      localparam int D80 = 128, D12 = 18, D34 = 52, D56 = 86;
`endif
      #1 rst = 1'b1;
      repeat (3) @(negedge int_clk);
      chk("reset_outputs", int'({pins, cmd_done, cmd_error}), 'hFC);
      rst = 1'b0;

      // preset red on both LEDs
      send("r");
      chk("r_done_pulse", int'(cmd_done), 1);
      @(negedge int_clk);
      chk("r_done_clear", int'(cmd_done), 0);
      settle(); measure();
      chk("r_led1_red_low", low[0], 255);
      chk("r_led2_red_low", low[3], 255);
      chk("r_led1_green_low", low[1], 0);

      // LED1 hex command
      send("1");
      sd = n_done;
      send("#80FF00");
      chk("hex_done_pulse", int'(cmd_done), 1);
      settle(); measure();
      chk("hex_done_count", n_done - sd, 1);
      chk("hex_led1_red_low", low[0], D80);
      chk("hex_led1_green_low", low[1], 255);
      chk("hex_led1_blue_low", low[2], 0);
      chk("hex_led2_red_low", low[3], 255);
      chk("hex_led2_green_low", low[4], 0);

      // bad digit aborts, next byte is a fresh command
      send("#12Z");
      chk("abort_err_pulse", int'(cmd_error), 1);
      send("g");
      chk("after_abort_g_done", int'(cmd_done), 1);
      settle(); measure();
      chk("g_led1_green_low", low[1], 255);
      chk("g_led1_red_low", low[0], 0);
      chk("g_led2_red_low", low[3], 255);

      // inter-byte timeout
      send("a");
      se = n_err;
      send("#12");
      repeat (TO - 1) @(negedge int_clk);
      chk("timeout_not_yet", int'(cmd_error), 0);
      @(negedge int_clk);
      chk("timeout_err_pulse", int'(cmd_error), 1);
      repeat (3) @(negedge int_clk);
      #1 chk("timeout_err_count", n_err - se, 1);

      // strobe on the expiry cycle continues the sequence
      @(negedge int_clk);
      send("#12");
      repeat (TO - 1) @(negedge int_clk);
      send("3");
      chk("expiry_strobe_no_err", int'(cmd_error), 0);
      send("456");
      chk("expiry_commit_done", int'(cmd_done), 1);
      settle(); measure();
      chk("x123456_led2_red_low", low[3], D12);
      chk("x123456_led1_green_low", low[1], D34);
      chk("x123456_led1_blue_low", low[2], D56);

      // mid-period change keeps old duty until counter 0
      send("w");
      settle();
      c = 0;
      while (m_cnt != 100 && c < 400) begin @(negedge int_clk); c++; end
      send("k");
      c = 0;
      while (!rgb1_red && c < 300) begin c++; @(negedge int_clk); end
      chk("midperiod_old_duty_cycles", c, 154);
      measure();
      chk("k_led1_red_low", low[0], 0);

      // async reset mid-hex
      send("w");
      settle();
      chk("w_all_lit", int'(pins), 0);
      sd = n_done; se = n_err;
      send("#8");
      #2 rst = 1'b1;
      #1 chk("async_reset_outputs", int'({pins, cmd_done, cmd_error}), 'hFC);
      @(negedge int_clk);
      rst = 1'b0;
      repeat (5) @(negedge int_clk);
      #1 chk("reset_midhex_no_pulses", (n_done - sd) + (n_err - se), 0);
      send("#800000");
      settle(); measure();
      chk("x800000_led1_red_low", low[0], D80);
      chk("x800000_led2_red_low", low[3], D80);
      chk("x800000_led1_green_low", low[1], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
